// File: rtl/cosim_pkg.sv
// Shared types and defaults for the retire-vs-reference cosimulation checker.
package cosim_pkg;

   localparam int DEPTH_DEF    = 8;
   localparam int MAX_MISS_DEF = 4;

   // One retired instruction as captured from the core.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] insn;
   } retire_entry_t;

   // IDLE: buffer only; ISSUE: present head to reference model;
   // WAIT: collect the miss result and pop; HALT: miss threshold reached.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HALT  = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/cosim_check_ctrl_retire_fifo.sv
// Retire buffer: up to two writes per cycle (lane0 then lane1), one read.
// Full/empty come from an occupancy counter; pointers wrap modulo DEPTH.
// wr1_i is only honoured together with wr0_i so lane order is preserved.
module retire_fifo
   import cosim_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr0_i,
   input  logic                         wr1_i,
   input  retire_entry_t                wdata0_i,
   input  retire_entry_t                wdata1_i,
   input  logic                         rd_i,
   output retire_entry_t                head_o,
   output logic                         empty_o,
   output logic                         two_free_o,
   output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   retire_entry_t   mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic            wr1_eff;

   assign wr1_eff = wr0_i & wr1_i;

   // Next pointers and occupancy = occupancy + pushes - pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr0_i) wr_ptr_d = wr_ptr_q + (wr1_eff ? PW'(2) : PW'(1));
      if (rd_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + OW'(wr0_i) + OW'(wr1_eff) - OW'(rd_i);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Entry storage; contents are don't-care while the slot is free.
   always_ff @(posedge clk) begin
      if (wr0_i)   mem_q[wr_ptr_q]          <= wdata0_i;
      if (wr1_eff) mem_q[wr_ptr_q + PW'(1)] <= wdata1_i;
   end

   assign head_o     = mem_q[rd_ptr_q];
   assign empty_o    = (occ_q == '0);
   assign two_free_o = (occ_q <= OW'(DEPTH - 2));
   assign occ_o      = occ_q;

endmodule

// File: rtl/cosim_check_ctrl.sv
// Buffers retired instructions from a dual-retire core and checks them one
// at a time against a lock-step reference model. The reference model
// consumes check_pc every clock; when no check is issued we drive ~ref_pc so
// it can never match. Handshake: a retire lane is accepted only in a cycle
// where retire_ready=1 at the clock edge; retire_valid=2'b10 is illegal.
module cosim_check_ctrl
   import cosim_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int MAX_MISS = MAX_MISS_DEF
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            enable,
   input  logic                            clear,
   input  logic [1:0]                      retire_valid,
   input  logic [63:0]                     retire_pc0,
   input  logic [63:0]                     retire_pc1,
   input  logic [31:0]                     retire_insn0,
   input  logic [31:0]                     retire_insn1,
   output logic                            retire_ready,
   output logic [63:0]                     check_pc,
   input  logic [63:0]                     ref_pc,
   input  logic [31:0]                     ref_insn,
   input  logic                            ref_miss,
   output logic [31:0]                     checked_cnt,
   output logic [$clog2(MAX_MISS+1)-1:0]   miss_cnt,
   output logic [15:0]                     insn_err_cnt,
   output logic [63:0]                     last_err_pc,
   output logic                            halt,
   output logic                            proto_err,
   output ctrl_state_e                     dbg_state_o,
   output logic [$clog2(DEPTH+1)-1:0]      dbg_occupancy_o
);

   localparam int MW = $clog2(MAX_MISS+1);

   ctrl_state_e      state_q, state_d;
   retire_entry_t    head, wdata0, wdata1;
   logic             fifo_empty, two_free;
   logic             push0, push1, issue, pop;
   logic [31:0]      checked_q;
   logic [MW-1:0]    miss_q, miss_next;
   logic [15:0]      insn_err_q;
   logic [63:0]      last_err_q;
   logic             proto_q;

   assign wdata0    = '{pc: retire_pc0, insn: retire_insn0};
   assign wdata1    = '{pc: retire_pc1, insn: retire_insn1};
   assign retire_ready = two_free && (state_q != HALT);
   assign push0     = retire_ready && retire_valid[0];
   assign push1     = retire_ready && (retire_valid == 2'b11);
   assign miss_next = miss_q + MW'(1);

   retire_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr0_i      (push0),
      .wr1_i      (push1),
      .wdata0_i   (wdata0),
      .wdata1_i   (wdata1),
      .rd_i       (pop),
      .head_o     (head),
      .empty_o    (fifo_empty),
      .two_free_o (two_free),
      .occ_o      (dbg_occupancy_o)
   );

   // State register; reset lands in IDLE so check_pc reverts to ~ref_pc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: clear wins, WAIT always completes its pop before leaving.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (enable) state_d = ISSUE;
            ISSUE:   if (!enable) state_d = IDLE;
                     else if (!fifo_empty) state_d = WAIT;
            WAIT:    if (ref_miss && (miss_next == MW'(MAX_MISS))) state_d = HALT;
                     else if (!enable) state_d = IDLE;
                     else state_d = ISSUE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs: a check is issued only from ISSUE with a head and no clear.
   always_comb begin
      issue    = 1'b0;
      pop      = 1'b0;
      halt     = 1'b0;
      check_pc = ~ref_pc;
      case (state_q)
         ISSUE: if (enable && !clear && !fifo_empty) begin
                   issue    = 1'b1;
                   check_pc = head.pc;
                end
         WAIT:  pop  = 1'b1;
         HALT:  halt = 1'b1;
         default: ;
      endcase
   end

   // Result counters and sticky flags; clear beats any same-cycle update.
   // The head is still the checked entry during WAIT, so its pc is used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checked_q  <= '0;
         miss_q     <= '0;
         insn_err_q <= '0;
         last_err_q <= '0;
         proto_q    <= 1'b0;
      end else if (clear) begin
         checked_q  <= '0;
         miss_q     <= '0;
         insn_err_q <= '0;
         last_err_q <= '0;
         proto_q    <= 1'b0;
      end else begin
         if (retire_valid == 2'b10) proto_q <= 1'b1;
         if (issue && (head.insn != ref_insn)) begin
            if (insn_err_q != 16'hFFFF) insn_err_q <= insn_err_q + 16'd1;
            last_err_q <= head.pc;
         end
         if (pop) begin
            if (ref_miss) begin
               miss_q     <= miss_next;
               last_err_q <= head.pc;
            end else begin
               checked_q  <= checked_q + 32'd1;
            end
         end
      end
   end

   assign checked_cnt  = checked_q;
   assign miss_cnt     = miss_q;
   assign insn_err_cnt = insn_err_q;
   assign last_err_pc  = last_err_q;
   assign proto_err    = proto_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cosim_check_ctrl.sv
// Bench for cosim_check_ctrl: directed scenarios plus random retire traffic,
// with a transaction-level reference model and reference-core stub.
module tb_cosim_check_ctrl;
   import cosim_pkg::*;

   localparam int DEPTH    = 8;
   localparam int MAX_MISS = 4;
   localparam int MW       = $clog2(MAX_MISS+1);
   localparam int OW       = $clog2(DEPTH+1);
   // Entry layout: {miss, ref_insn[31:0], insn[31:0], pc[63:0]}
   localparam int W        = 129;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              enable, clear, ref_miss;
   logic [1:0]        retire_valid;
   logic [63:0]       retire_pc0, retire_pc1, ref_pc, check_pc, last_err_pc;
   logic [31:0]       retire_insn0, retire_insn1, ref_insn, checked_cnt;
   logic              retire_ready, halt, proto_err;
   logic [MW-1:0]     miss_cnt;
   logic [15:0]       insn_err_cnt;
   ctrl_state_e       dbg_state;
   logic [OW-1:0]     dbg_occ;

   cosim_check_ctrl #(.DEPTH(DEPTH), .MAX_MISS(MAX_MISS)) dut (
      .clk (clk), .rst_n (rst_n), .enable (enable), .clear (clear),
      .retire_valid (retire_valid),
      .retire_pc0 (retire_pc0), .retire_pc1 (retire_pc1),
      .retire_insn0 (retire_insn0), .retire_insn1 (retire_insn1),
      .retire_ready (retire_ready), .check_pc (check_pc),
      .ref_pc (ref_pc), .ref_insn (ref_insn), .ref_miss (ref_miss),
      .checked_cnt (checked_cnt), .miss_cnt (miss_cnt),
      .insn_err_cnt (insn_err_cnt), .last_err_pc (last_err_pc),
      .halt (halt), .proto_err (proto_err),
      .dbg_state_o (dbg_state), .dbg_occupancy_o (dbg_occ)
   );

   // ---------------- scoreboard / model state ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] inflight, nxt0, nxt1;
   logic         inflight_v, m_halted, m_proto, force_miss;
   logic [31:0]  m_checked;
   logic [15:0]  m_ierr;
   logic [63:0]  m_last;
   int           m_miss, planned_miss;
   int           n_vec = 0;
   int           n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [63:0] pc, input logic [31:0] insn,
                                       input logic [31:0] rinsn, input logic miss);
      return {miss, rinsn, insn, pc};
   endfunction

   task automatic gen_entry(output logic [W-1:0] ent);
      logic [63:0] pc;
      logic [31:0] insn, rinsn;
      logic        miss;
      pc    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC)};
      insn  = $urandom;
      rinsn = ($urandom_range(0, 3) == 0) ? (insn ^ (32'h1 << $urandom_range(0, 31))) : insn;
      miss  = 1'b0;
      if (planned_miss < MAX_MISS - 1 && $urandom_range(0, 7) == 0) begin
         miss = 1'b1;
         planned_miss++;
      end
      ent = mk(pc, insn, rinsn, miss);
   endtask

   task automatic model_reset();
      exp_q.delete();
      inflight_v = 1'b0; inflight = '0;
      m_halted = 1'b0; m_proto = 1'b0;
      m_checked = '0; m_ierr = '0; m_last = '0;
      m_miss = 0; planned_miss = 0;
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Called at a negedge. Drives inputs, plays the reference-core stub,
   // compares all outputs against the model, then advances the model
   // across the following posedge.
   task automatic cycle(input logic [1:0] rv, input logic en, input logic clr);
      logic         issued, acc;
      logic [W-1:0] e, hd;
      int           occ;
      e = '0;
      retire_valid = rv; enable = en; clear = clr;
      retire_pc0 = nxt0[63:0]; retire_insn0 = nxt0[95:64];
      retire_pc1 = nxt1[63:0]; retire_insn1 = nxt1[95:64];
      if (inflight_v)      ref_miss = inflight[128];
      else if (force_miss) ref_miss = 1'b1;
      else                 ref_miss = 1'($urandom_range(0, 1));
      if (exp_q.size() > 0) begin
         hd       = exp_q[0];
         ref_pc   = hd[128] ? (hd[63:0] ^ 64'h10) : hd[63:0];
         ref_insn = hd[127:96];
      end else begin
         ref_pc   = {32'h0, $urandom};
         ref_insn = $urandom;
      end
      #1;
      occ = exp_q.size() + (inflight_v ? 1 : 0);
      acc = !m_halted && (occ <= DEPTH - 2);
      check("retire_ready", 64'(retire_ready), 64'(acc));
      check("halt",         64'(halt),         64'(m_halted));
      check("proto_err",    64'(proto_err),    64'(m_proto));
      check("checked_cnt",  64'(checked_cnt),  64'(m_checked));
      check("miss_cnt",     64'(miss_cnt),     64'(m_miss));
      check("insn_err_cnt", 64'(insn_err_cnt), 64'(m_ierr));
      check("last_err_pc",  last_err_pc,       m_last);
      check("occupancy",    64'(dbg_occ),      64'(occ));
      issued = (check_pc !== ~ref_pc);
      if (!en || clr || inflight_v || m_halted || exp_q.size() == 0)
         check("no_issue", 64'(issued), 64'd0);
      if (issued && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("check_pc", check_pc, e[63:0]);
      end else begin
         issued = 1'b0;
      end
      @(posedge clk);
      if (clr) begin
         m_checked = '0; m_miss = 0; m_ierr = '0; m_last = '0;
         m_proto = 1'b0; m_halted = 1'b0; planned_miss = 0;
      end else begin
         if (inflight_v) begin
            if (inflight[128]) begin
               m_miss++;
               m_last = inflight[63:0];
               if (m_miss == MAX_MISS) m_halted = 1'b1;
            end else begin
               m_checked = m_checked + 32'd1;
            end
         end
         if (issued && (e[127:96] != e[95:64])) begin
            if (m_ierr != 16'hFFFF) m_ierr = m_ierr + 16'd1;
            m_last = e[63:0];
         end
         if (rv == 2'b10) m_proto = 1'b1;
      end
      if (acc && rv[0]) exp_q.push_back(nxt0);
      if (acc && rv == 2'b11) exp_q.push_back(nxt1);
      inflight_v = issued;
      inflight   = e;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * DEPTH + 10; i++) begin
         if (exp_q.size() == 0 && !inflight_v) break;
         cycle(2'b00, 1'b1, 1'b0);
      end
      check("drained", 64'(exp_q.size() + (inflight_v ? 1 : 0)), 64'd0);
   endtask

   // Hang guard.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; enable = 1'b0; clear = 1'b0; ref_miss = 1'b0; force_miss = 1'b0;
      retire_valid = 2'b00; retire_pc0 = '0; retire_pc1 = '0;
      retire_insn0 = '0; retire_insn1 = '0;
      ref_pc = 64'h1234_5678_9ABC_DEF0; ref_insn = '0;
      nxt0 = '0; nxt1 = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_check_pc",  check_pc, 64'hEDCB_A987_6543_210F);
      check("rst_ready",     64'(retire_ready), 64'd1);
      check("rst_halt",      64'(halt), 64'd0);
      check("rst_checked",   64'(checked_cnt), 64'd0);
      check("rst_last_err",  last_err_pc, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Match: two retires, both checked after four cycles.
      nxt0 = mk(64'h8000_0000, 32'h0000_0013, 32'h0000_0013, 1'b0);
      nxt1 = mk(64'h8000_0004, 32'h0010_0093, 32'h0010_0093, 1'b0);
      cycle(2'b11, 1'b1, 1'b0);
      repeat (4) cycle(2'b00, 1'b1, 1'b0);
      check("match_checked", 64'(checked_cnt), 64'd2);
      check("match_miss",    64'(miss_cnt), 64'd0);
      check("match_occ",     64'(dbg_occ), 64'd0);

      // Miss threshold: four consecutive misses halt the checker.
      nxt0 = mk(64'h8000_1000, 32'h13, 32'h13, 1'b1);
      nxt1 = mk(64'h8000_1004, 32'h13, 32'h13, 1'b1);
      cycle(2'b11, 1'b1, 1'b0);
      nxt0 = mk(64'h8000_1008, 32'h13, 32'h13, 1'b1);
      nxt1 = mk(64'h8000_100C, 32'h13, 32'h13, 1'b1);
      cycle(2'b11, 1'b1, 1'b0);
      for (int i = 0; i < 20 && !m_halted; i++) cycle(2'b00, 1'b1, 1'b0);
      cycle(2'b11, 1'b1, 1'b0);
      check("halt_set",      64'(halt), 64'd1);
      check("halt_ready",    64'(retire_ready), 64'd0);
      check("halt_last_err", last_err_pc, 64'h8000_100C);
      check("halt_miss",     64'(miss_cnt), 64'd4);
      cycle(2'b00, 1'b0, 1'b1);
      check("clear_halt",    64'(halt), 64'd0);
      check("clear_miss",    64'(miss_cnt), 64'd0);

      // Instruction mismatch: counted, recorded, and still a matched check.
      nxt0 = mk(64'h8000_2000, 32'h0000_0013, 32'h0010_0093, 1'b0);
      cycle(2'b01, 1'b1, 1'b0);
      repeat (3) cycle(2'b00, 1'b1, 1'b0);
      check("ierr_cnt",      64'(insn_err_cnt), 64'd1);
      check("ierr_last",     last_err_pc, 64'h8000_2000);
      check("ierr_checked",  64'(checked_cnt), 64'd1);

      // Backpressure with checking disabled.
      for (int i = 0; i < 3; i++) begin
         gen_entry(nxt0); gen_entry(nxt1);
         cycle(2'b11, 1'b0, 1'b0);
      end
      check("bp_occ6",   64'(dbg_occ), 64'd6);
      check("bp_ready6", 64'(retire_ready), 64'd1);
      gen_entry(nxt0); gen_entry(nxt1);
      cycle(2'b11, 1'b0, 1'b0);
      check("bp_occ8",   64'(dbg_occ), 64'd8);
      check("bp_ready8", 64'(retire_ready), 64'd0);
      cycle(2'b11, 1'b0, 1'b0);

      // Protocol error is sticky; clear drops it but keeps the FIFO.
      cycle(2'b10, 1'b0, 1'b0);
      check("proto_set", 64'(proto_err), 64'd1);
      check("proto_occ", 64'(dbg_occ), 64'd8);
      cycle(2'b00, 1'b0, 1'b0);
      check("proto_sticky", 64'(proto_err), 64'd1);
      cycle(2'b00, 1'b0, 1'b1);
      check("proto_clr",     64'(proto_err), 64'd0);
      check("clr_keep_fifo", 64'(dbg_occ), 64'd8);
      drain();

      // Reset while a miss result is in flight.
      nxt0 = mk(64'h8000_3000, 32'h13, 32'h13, 1'b1);
      cycle(2'b01, 1'b1, 1'b0);
      for (int i = 0; i < 8 && !inflight_v; i++) cycle(2'b00, 1'b1, 1'b0);
      check("reached_wait", 64'(inflight_v), 64'd1);
      ref_miss = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rw_check_pc", check_pc, ~ref_pc);
      check("rw_ready",    64'(retire_ready), 64'd1);
      check("rw_miss",     64'(miss_cnt), 64'd0);
      check("rw_checked",  64'(checked_cnt), 64'd0);
      check("rw_last_err", last_err_pc, 64'd0);
      check("rw_occ",      64'(dbg_occ), 64'd0);
      model_reset();
      repeat (2) begin
         @(negedge clk);
         check("rw_hold_check_pc", check_pc, ~ref_pc);
      end
      rst_n = 1'b1;
      force_miss = 1'b1;
      repeat (2) cycle(2'b00, 1'b1, 1'b0);
      force_miss = 1'b0;
      check("rw_miss_ignored", 64'(miss_cnt), 64'd0);

      // Random retire traffic with enable toggling.
      for (int i = 0; i < 600; i++) begin
         logic [1:0] rv;
         int         r;
         r  = $urandom_range(0, 19);
         rv = (r < 8) ? 2'b00 : (r < 13) ? 2'b01 : (r < 19) ? 2'b11 : 2'b10;
         gen_entry(nxt0); gen_entry(nxt1);
         cycle(rv, ($urandom_range(0, 4) != 0), 1'b0);
      end
      drain();
      check("final_halt", 64'(halt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cosim_check_ctrl.md
COSIM_CHECK_CTRL -- requirements
Module: cosim_check_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: retire FIFO entries, power of two, >= 4.
REQ-002 SHALL have parameter MAX_MISS, default 4: miss count that forces HALT, >= 1.
REQ-003 SHALL have the following ports; one clock, reset asynchronous and active-low:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  start checking (level)
- clear  in  1  synchronous clear of counters, sticky flags and HALT
- retire_valid  in  2  per-lane retire strobe from the DUT core
- retire_pc0, retire_pc1  in  64  retired PC per lane
- retire_insn0, retire_insn1  in  32  retired instruction per lane
- retire_ready  out  1  FIFO can accept two entries
- check_pc  out  64  to the reference-model interface PC-check input
- ref_pc  in  64  reference model's current PC
- ref_insn  in  32  reference model's current instruction
- ref_miss  in  1  reference model's miss flag for the previous check
- checked_cnt  out  32  count of matched checks (wraps)
- miss_cnt  out  $clog2(MAX_MISS+1)  count of PC misses
- insn_err_cnt  out  16  instruction mismatches (saturates at 0xFFFF)
- last_err_pc  out  64  PC of the most recent miss or instruction mismatch
- halt  out  1  threshold reached
- proto_err  out  1  sticky flag for retire_valid == 2'b10

Function
REQ-004 The reference model consumes check_pc on every clk edge and advances on a match, so check_pc SHALL equal ~ref_pc in every cycle that does not issue a check.
REQ-005 FIFO push SHALL occur only when retire_ready=1: lane0 first, then lane1 (when retire_valid=2'b11).
REQ-006 retire_ready SHALL equal (free entries >= 2).
REQ-007 retire_valid=2'b10 SHALL set proto_err and push nothing.
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT and HALT.
REQ-009 IDLE -> ISSUE when enable=1; in IDLE the FIFO accepts pushes but nothing is issued.
REQ-010 ISSUE, FIFO non-empty: the block SHALL drive check_pc=head.pc, compare head.insn with ref_insn, and go to WAIT; FIFO empty: stay in ISSUE.
REQ-011 An insn mismatch in ISSUE SHALL increment insn_err_cnt (saturating) and load last_err_pc=head.pc.
REQ-012 WAIT SHALL pop the head unconditionally; it lasts exactly one cycle.
- ref_miss=0: checked_cnt+1, then go to ISSUE.
- ref_miss=1: miss_cnt+1 and last_err_pc=popped pc; go to HALT if the new miss_cnt == MAX_MISS, else to ISSUE.
REQ-013 Check throughput SHALL be one entry per two cycles; the first issue occurs no earlier than the cycle after the push.
REQ-014 HALT SHALL assert halt=1 and retire_ready=0, issue no pops or checks, and leave only on clear or reset.
REQ-015 Deasserting enable in ISSUE SHALL return the FSM to IDLE; in WAIT it SHALL complete the pop first and then go to IDLE.
REQ-016 clear=1 SHALL zero all counters, last_err_pc, proto_err and halt and force IDLE, without flushing the FIFO; clear SHALL take priority over an increment in the same cycle.
REQ-017 Simultaneous push and pop SHALL be legal; occupancy SHALL update as occupancy + pushes - pop.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an occupancy counter of width $clog2(DEPTH+1).
REQ-019 No output SHALL depend combinationally on ref_* except check_pc (~ref_pc).

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, an empty FIFO, all counters 0, last_err_pc=0, halt=0, proto_err=0 and retire_ready=1.
REQ-021 A reset in WAIT SHALL discard the in-flight result; the next ref_miss SHALL be ignored.
REQ-022 check_pc SHALL equal ~ref_pc while in reset.

Structure
REQ-023 Package cosim_pkg SHALL hold: the retire_entry_t struct (pc 64, insn 32), the ctrl_state_e enum, and the default constants DEPTH_DEF and MAX_MISS_DEF.
REQ-024 The storage SHALL be one sub-module, retire_fifo: 2-write, 1-read, parameterised by DEPTH; the FSM and counters live in cosim_check_ctrl.

Verification
REQ-025 The bench SHALL cover these directed scenarios, with a behavioural reference-model stub:
- Match: enable=1, push pc 0x80000000/0x80000004 (2'b11), reference PCs matching -> checked_cnt=2 after 4 cycles, miss_cnt=0, FIFO empty.
- Miss threshold (MAX_MISS=4): stub returns ref_miss=1 on four consecutive checks -> halt=1 in the cycle after the 4th WAIT, retire_ready=0, last_err_pc = 4th PC.
- Insn mismatch: head insn 0x00000013, ref_insn 0x00100093 -> insn_err_cnt=1, last_err_pc=head pc, checked_cnt still increments.
- Backpressure: DEPTH=8, enable=0, push 3 pairs -> occupancy 6, retire_ready=1; push 1 pair -> occupancy 8, retire_ready=0; check_pc=~ref_pc throughout.
- Protocol error: retire_valid=2'b10 -> proto_err=1 sticky, occupancy unchanged; clear=1 -> proto_err=0.
- Reset mid-WAIT: assert rst_n=0 in WAIT -> all outputs at reset values in the same cycle, FIFO empty; after release, the first ref_miss is ignored.
